// File: rtl/irb_pkg.sv
// Shared constants and types for the IRB datapath: RAM_KEX geometry and the
// kex_loader state encoding.
package irb_pkg;

   localparam int WG_W       = 8;
   localparam int Npar       = 4;
   localparam int KEX_N_ELEM = 16;

   localparam int KEX_W = WG_W + $clog2(Npar + 1);
   localparam int CNT_W = $clog2(KEX_N_ELEM + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      FINISH = 2'd2
   } kex_ld_state_t;

   // Requested length clamped to the RAM depth so addresses stay in range.
   function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] n);
      return (n > CNT_W'(KEX_N_ELEM)) ? CNT_W'(KEX_N_ELEM) : n;
   endfunction

endpackage

// File: rtl/kex_loader.sv
// Fills RAM_KEX from external memory: issues word reads from base_addr upward,
// writes the in-order responses to RAM addresses 0.., then pulses done.
module kex_loader
   import irb_pkg::*;
#(
   parameter int MEM_AW = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [MEM_AW-1:0] base_addr,
   input  logic [CNT_W-1:0]  n_elem,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [MEM_AW-1:0] mem_req_addr,
   input  logic              mem_rsp_valid,
   input  logic [KEX_W-1:0]  mem_rsp_data,
   output logic [CNT_W-1:0]  ram_addr,
   output logic [KEX_W-1:0]  ram_data,
   output logic              ram_write,
   output logic              busy,
   output logic              done
);

   kex_ld_state_t     state, state_next;
   logic [MEM_AW-1:0] base_q;
   logic [CNT_W-1:0]  n_len;
   logic [CNT_W-1:0]  req_cnt;
   logic [CNT_W-1:0]  rsp_cnt;
   logic              start_ok;
   logic              req_fire;
   logic              rsp_fire;
   logic              rsp_last;

   always_comb begin
      state_next = state;
      start_ok   = 1'b0;
      done       = 1'b0;
      busy       = (state != IDLE);
      case (state)
         IDLE: begin
            if (start) begin
               start_ok   = 1'b1;
               state_next = (n_elem == '0) ? FINISH : LOAD;
            end
         end
         LOAD: begin
            if (rsp_last) begin
               state_next = FINISH;
            end
         end
         FINISH: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         base_q <= '0;
         n_len  <= '0;
      end else begin
         state <= state_next;
         if (start_ok) begin
            base_q <= base_addr;
            n_len  <= clamp_len(n_elem);
         end
      end
   end

   // Request side: address is combinational on req_cnt, so it holds until accepted.
   always_comb begin
      mem_req_valid = (state == LOAD) && (req_cnt < n_len);
      mem_req_addr  = base_q + MEM_AW'(req_cnt);
      req_fire      = mem_req_valid && mem_req_ready;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_cnt <= '0;
      end else if (start_ok) begin
         req_cnt <= '0;
      end else if (req_fire) begin
         req_cnt <= req_cnt + CNT_W'(1);
      end
   end

   // Response side: anything arriving outside LOAD or past n_len is dropped.
   always_comb begin
      rsp_fire = (state == LOAD) && mem_rsp_valid && (rsp_cnt < n_len);
      rsp_last = rsp_fire && (rsp_cnt == n_len - CNT_W'(1));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_cnt   <= '0;
         ram_addr  <= '0;
         ram_data  <= '0;
         ram_write <= 1'b0;
      end else begin
         ram_write <= rsp_fire;
         if (start_ok) begin
            rsp_cnt <= '0;
         end else if (rsp_fire) begin
            ram_addr <= rsp_cnt;
            ram_data <= mem_rsp_data;
            rsp_cnt  <= rsp_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_kex_loader.sv
// Bench for kex_loader: table of load scenarios driven through a memory
// responder and a RAM_KEX model, plus reset-during-load sequence.
module tb_kex_loader;
   import irb_pkg::*;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [31:0]       base_addr = '0;
   logic [CNT_W-1:0]  n_elem = '0;
   logic              mem_req_valid;
   logic              mem_req_ready = 1'b0;
   logic [31:0]       mem_req_addr;
   logic              mem_rsp_valid = 1'b0;
   logic [KEX_W-1:0]  mem_rsp_data = '0;
   logic [CNT_W-1:0]  ram_addr;
   logic [KEX_W-1:0]  ram_data;
   logic              ram_write;
   logic              busy;
   logic              done;

   kex_loader #(.MEM_AW(32)) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .n_elem(n_elem),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .ram_addr(ram_addr), .ram_data(ram_data), .ram_write(ram_write),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]      base;
      logic [CNT_W-1:0] n;
      int               pct;
      int               dly;
      int               exp_n;
      logic [KEX_W-1:0] d0;
      logic [KEX_W-1:0] d1;
      bit               mid;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [31:0]      cur_base;
   logic [KEX_W-1:0] cur_d0, cur_d1;
   int               cur_pct, cur_dly, exp_n;
   int               req_seen, wr_cnt, rsp_k;
   int               q[$];
   logic [31:0]      req_log [0:31];
   logic [KEX_W-1:0] tb_ram  [0:31];
   logic             prev_valid = 1'b0, prev_ready = 1'b0;
   logic [31:0]      prev_addr = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [KEX_W-1:0] word_at(input int k);
      return KEX_W'(cur_d0 + KEX_W'(k) * cur_d1);
   endfunction

   // One clock: observe this cycle's outputs at negedge, then drive inputs.
   task automatic step(input logic st);
      @(negedge clk);
      cyc++;
      if (prev_valid && !prev_ready && !reset) begin
         chk("req_stable_valid", 64'(mem_req_valid), 64'd1);
         chk("req_stable_addr", 64'(mem_req_addr), 64'(prev_addr));
      end
      if (ram_write) begin
         if (wr_cnt < exp_n) begin
            chk("ram_addr", 64'(ram_addr), 64'(wr_cnt));
            chk("ram_data", 64'(ram_data), 64'(word_at(wr_cnt)));
         end else begin
            chk("extra_write", 64'(ram_write), 64'd0);
         end
         tb_ram[ram_addr] = ram_data;
         wr_cnt++;
      end
      if (q.size() > 0 && q[0] <= cyc) begin
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = word_at(rsp_k);
         rsp_k++;
         void'(q.pop_front());
      end else begin
         mem_rsp_valid = 1'b0;
         mem_rsp_data  = KEX_W'($urandom);
      end
      mem_req_ready = (cur_pct >= 100) ? 1'b1 : (int'($urandom_range(0, 99)) < cur_pct);
      if (mem_req_valid && mem_req_ready) begin
         if (req_seen < exp_n)
            chk("req_addr", 64'(mem_req_addr), 64'(32'(cur_base + 32'(req_seen))));
         else
            chk("extra_req", 64'(mem_req_valid), 64'd0);
         req_log[req_seen % 32] = mem_req_addr;
         req_seen++;
         q.push_back(cyc + 1 + int'($urandom_range(0, cur_dly)));
      end
      prev_valid = mem_req_valid;
      prev_ready = mem_req_ready;
      prev_addr  = mem_req_addr;
      start      = st;
   endtask

   task automatic setup(input vec_t v);
      cur_base = v.base; cur_d0 = v.d0; cur_d1 = v.d1;
      cur_pct = v.pct; cur_dly = v.dly; exp_n = v.exp_n;
      req_seen = 0; wr_cnt = 0; rsp_k = 0;
      q.delete();
      for (int i = 0; i < 32; i++) tb_ram[i] = '0;
      base_addr = v.base;
      n_elem    = v.n;
   endtask

   task automatic run_load(input vec_t v);
      bit got_done;
      got_done = 0;
      setup(v);
      step(1'b1);
      chk("idle_before_start", 64'(busy), 64'd0);
      chk("done_single", 64'(done), 64'd0);
      for (int it = 0; it < 400 && !got_done; it++) begin
         if (v.mid && it == 3) begin
            base_addr = 32'hDEAD_0000;
            n_elem    = CNT_W'(1);
         end
         step(v.mid && it == 3);
         if (it == 0) begin
            chk("busy_after_start", 64'(busy), 64'd1);
            if (v.exp_n > 0) chk("first_req_valid", 64'(mem_req_valid), 64'd1);
            else             chk("zero_len_done", 64'(done), 64'd1);
         end
         if (done) begin
            got_done = 1;
            chk("done_with_last_write", 64'(ram_write), 64'(v.exp_n > 0));
            chk("write_count", 64'(wr_cnt), 64'(v.exp_n));
            chk("req_count", 64'(req_seen), 64'(v.exp_n));
         end
      end
      if (!got_done) chk("done_timeout", 64'(got_done), 64'd1);
      for (int i = 0; i < v.exp_n; i++)
         chk("ram_readback", 64'(tb_ram[i]), 64'(word_at(i)));
   endtask

   vec_t vecs [0:7];
   vec_t rv;

   initial begin
      vecs[0] = '{32'h0000_0100, 5'd4,  100, 0, 4,  11'h00A, 11'h001, 1'b0};
      vecs[1] = '{32'h0000_2000, 5'd21, 100, 0, 16, 11'h3F1, 11'h155, 1'b0};
      vecs[2] = '{32'h0000_0040, 5'd10, 50,  7, 10, 11'h123, 11'h0B7, 1'b1};
      vecs[3] = '{32'hFFFF_FFFE, 5'd4,  100, 0, 4,  11'h7FF, 11'h003, 1'b0};
      vecs[4] = '{32'h0000_0999, 5'd0,  100, 0, 0,  11'h000, 11'h000, 1'b0};
      vecs[5] = '{32'h0000_0007, 5'd16, 70,  3, 16, 11'h055, 11'h1AB, 1'b0};
      vecs[6] = '{32'h0000_3000, 5'd31, 30,  5, 16, 11'h001, 11'h002, 1'b0};
      vecs[7] = '{32'h0000_0010, 5'd1,  100, 2, 1,  11'h006, 11'h000, 1'b0};

      cur_pct = 100; cur_dly = 0; exp_n = 0; cur_base = '0; cur_d0 = '0; cur_d1 = '0;
      req_seen = 0; wr_cnt = 0; rsp_k = 0;
      repeat (3) @(negedge clk);
      chk("reset_valid", 64'(mem_req_valid), 64'd0);
      chk("reset_addr", 64'(mem_req_addr), 64'd0);
      chk("reset_ram", 64'({ram_write, ram_addr, ram_data}), 64'd0);
      chk("reset_busy_done", 64'({busy, done}), 64'd0);
      reset = 1'b0;

      for (int v = 0; v < 8; v++) begin
         run_load(vecs[v]);
         if (v == 1) chk("clamp_last_addr", 64'(ram_addr), 64'(KEX_N_ELEM - 1));
         if (v == 3) begin
            chk("wrap_addr1", 64'(req_log[1]), 64'hFFFF_FFFF);
            chk("wrap_addr2", 64'(req_log[2]), 64'h0);
            chk("wrap_addr3", 64'(req_log[3]), 64'h1);
         end
      end

      // Reset after two of six responses; late responses must be dropped.
      rv = '{32'h0000_0800, 5'd6, 100, 0, 6, 11'h111, 11'h011, 1'b0};
      setup(rv);
      step(1'b1);
      for (int it = 0; it < 100 && wr_cnt < 2; it++) step(1'b0);
      chk("writes_before_reset", 64'(wr_cnt), 64'd2);
      reset = 1'b1;
      #1;
      chk("async_reset_valid", 64'(mem_req_valid), 64'd0);
      chk("async_reset_addr", 64'(mem_req_addr), 64'd0);
      chk("async_reset_ram", 64'({ram_write, ram_addr, ram_data}), 64'd0);
      chk("async_reset_busy_done", 64'({busy, done}), 64'd0);
      exp_n = wr_cnt;
      prev_valid = 1'b0;
      step(1'b0);
      reset = 1'b0;
      for (int it = 0; it < 12; it++) step(1'b0);
      chk("late_rsp_dropped", 64'(wr_cnt), 64'd2);
      chk("idle_after_reset", 64'(busy), 64'd0);

      rv = '{32'h0000_0500, 5'd3, 100, 1, 3, 11'h0F0, 11'h00F, 1'b0};
      run_load(rv);

      step(1'b0);
      chk("final_idle", 64'({busy, done}), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1);
   end

endmodule
